// File: rtl/ternary_serial_adder.sv
// -----------------------------------------------------------------------------
// ternary_serial_adder
//   Digit-serial unsigned ternary adder. Two DIGITS-digit operands (2-bit code
//   per digit: 00=0, 01=1, 10=2, 11=invalid) are taken over a valid/ready
//   handshake and added one digit per clock, least significant digit first.
//   The sum, carry-out and an invalid-digit flag are then offered over a
//   second valid/ready handshake.
//
//   Optional feature macro: TERNARY_SUB_EN
//     defined   : sub=1 at accept computes a - b by ternary complement of b
//                 (each digit becomes 2 - b_i, initial carry forced to 1,
//                 cIn ignored). cOut=1 means no borrow.
//     undefined : sub is ignored and no complement logic is built.
// -----------------------------------------------------------------------------
module ternary_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                inValid,
   output logic                inReady,
   input  logic [2*DIGITS-1:0] a,
   input  logic [2*DIGITS-1:0] b,
   input  logic                cIn,
   input  logic                sub,
   output logic                outValid,
   input  logic                outReady,
   output logic [2*DIGITS-1:0] s,
   output logic                cOut,
   output logic                err
);

   localparam int W  = 2 * DIGITS;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // Operand latches and running arithmetic state
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [CW-1:0] cnt;
   logic          carry;

   // Result registers, driven straight onto the outputs
   logic [W-1:0]  s_q;
   logic          cout_q;
   logic          err_q;

   // Per-digit datapath
   logic          accept;
   logic          last_digit;
   logic [1:0]    a_dig;
   logic [1:0]    b_dig;
   logic          a_bad;
   logic          b_bad;
   logic [1:0]    a_val;
   logic [1:0]    b_val;
   logic [1:0]    b_eff;
   logic [2:0]    t;
   logic [1:0]    sum_dig;
   logic          carry_nxt;
   logic          carry_init;

`ifdef TERNARY_SUB_EN
   logic          sub_q;
`else
   logic          unused_sub;
   assign unused_sub = sub;
`endif

   assign accept     = inValid && (state == IDLE);
   assign last_digit = (cnt == LAST);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // Hold the control state; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge resetN) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // in the design samples pre-edge values, independent of block order.
      if (!resetN) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   // IDLE waits for operands, RUN walks the digits, DONE waits for the consumer.
   always_comb begin
      // NOTE: default assignment first so no branch leaves state_nxt
      // unassigned, which would otherwise infer a latch.
      state_nxt = state;
      unique case (state)
         IDLE: if (inValid)    state_nxt = RUN;
         RUN:  if (last_digit) state_nxt = DONE;
         DONE: if (outReady)   state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   // Handshake outputs decode directly from the state.
   always_comb begin
      inReady  = (state == IDLE);
      outValid = (state == DONE);
   end

   // ---------------------------------------------------------------------------
   // Digit datapath
   // ---------------------------------------------------------------------------
   // Select digit cnt of each operand, squash invalid codes to 0, optionally
   // complement b, then form the ternary digit sum and carry.
   always_comb begin
      a_dig = a_q[{cnt, 1'b0} +: 2];
      b_dig = b_q[{cnt, 1'b0} +: 2];
      a_bad = (a_dig == 2'b11);
      b_bad = (b_dig == 2'b11);
      a_val = a_bad ? 2'd0 : a_dig;
      b_val = b_bad ? 2'd0 : b_dig;
`ifdef TERNARY_SUB_EN
      b_eff = sub_q ? (2'd2 - b_val) : b_val;
`else
      b_eff = b_val;
`endif
      t         = {1'b0, a_val} + {1'b0, b_eff} + {2'b00, carry};
      carry_nxt = (t >= 3'd3);
      sum_dig   = carry_nxt ? 2'(t - 3'd3) : t[1:0];
   end

   // Carry seeded at accept: forced to 1 for subtraction, else cIn.
   always_comb begin
`ifdef TERNARY_SUB_EN
      carry_init = sub ? 1'b1 : cIn;
`else
      carry_init = cIn;
`endif
   end

   // ---------------------------------------------------------------------------
   // Operand capture and digit counter
   // ---------------------------------------------------------------------------
   // Latch operands on accept and step the digit counter through RUN.
   always_ff @(posedge clk or negedge resetN) begin
      // NOTE: the operand latches are ordinary flops, not a memory array, so
      // they are reset too; this keeps them defined before the first accept.
      if (!resetN) begin
         a_q   <= '0;
         b_q   <= '0;
         cnt   <= '0;
         carry <= 1'b0;
`ifdef TERNARY_SUB_EN
         sub_q <= 1'b0;
`endif
      end else if (accept) begin
         a_q   <= a;
         b_q   <= b;
         cnt   <= '0;
         carry <= carry_init;
`ifdef TERNARY_SUB_EN
         sub_q <= sub;
`endif
      end else if (state == RUN) begin
         carry <= carry_nxt;
         if (!last_digit) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Result registers
   // ---------------------------------------------------------------------------
   // Build the sum digit by digit, accumulate the sticky error flag, and
   // record the carry out of the top digit; all hold stable through DONE.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (accept) begin
         s_q   <= '0;
         err_q <= 1'b0;
      end else if (state == RUN) begin
         s_q[{cnt, 1'b0} +: 2] <= sum_dig;
         err_q                 <= err_q | a_bad | b_bad;
         if (last_digit) begin
            cout_q <= carry_nxt;
         end
      end
   end

   assign s    = s_q;
   assign cOut = cout_q;
   assign err  = err_q;

endmodule

// File: tb/tb_ternary_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_ternary_serial_adder
//   Self-checking bench for ternary_serial_adder (DIGITS=4). A behavioural model
//   converts operands to integers, adds (or subtracts via 3^DIGITS complement)
//   and converts back to digit codes. A compare process checks the result on
//   every cycle outValid is high; directed cases pin literal results.
// -----------------------------------------------------------------------------
module tb_ternary_serial_adder;

   localparam int DIGITS = 4;
   localparam int W      = 2 * DIGITS;

   logic         clk      = 1'b0;
   logic         resetN   = 1'b0;
   logic         inValid  = 1'b0;
   logic         outReady = 1'b0;
   logic         cIn      = 1'b0;
   logic         sub      = 1'b0;
   logic [W-1:0] a        = '0;
   logic [W-1:0] b        = '0;
   logic         inReady;
   logic         outValid;
   logic [W-1:0] s;
   logic         cOut;
   logic         err;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [W-1:0] exp_s = '0;
   logic         exp_c = 1'b0;
   logic         exp_e = 1'b0;

   ternary_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk      (clk),
      .resetN   (resetN),
      .inValid  (inValid),
      .inReady  (inReady),
      .a        (a),
      .b        (b),
      .cIn      (cIn),
      .sub      (sub),
      .outValid (outValid),
      .outReady (outReady),
      .s        (s),
      .cOut     (cOut),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: integer arithmetic on digit values, invalid codes read as 0.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic msub,
                                 output logic [W-1:0] ms, output logic mco, output logic me);
      int av, bv, p, sum;
      logic [1:0] d;
      av = 0; bv = 0; p = 1; me = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         d = ma[2*i +: 2];
         if (d == 2'b11) begin me = 1'b1; d = 2'd0; end
         av += int'(d) * p;
         d = mb[2*i +: 2];
         if (d == 2'b11) begin me = 1'b1; d = 2'd0; end
         bv += int'(d) * p;
         p *= 3;
      end
`ifdef TERNARY_SUB_EN
      if (msub) sum = av - bv + p;
      else      sum = av + bv + int'(mc);
`else
      sum = av + bv + int'(mc);
      if (msub) sum = sum + 0;
`endif
      mco = (sum >= p);
      sum = sum % p;
      ms  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         ms[2*i +: 2] = 2'(sum % 3);
         sum = sum / 3;
      end
   endfunction

   // Replace invalid codes with random valid digits.
   function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++)
         if (r[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'($urandom_range(0, 2));
      return r;
   endfunction

   // Compare process: result must match the model whenever it is offered.
   always @(negedge clk) begin
      if (resetN && outValid) begin
         check("s", 32'(s), 32'(exp_s));
         check("cOut", 32'(cOut), 32'(exp_c));
         check("err", 32'(err), 32'(exp_e));
         check("inReady_in_done", 32'(inReady), 32'd0);
      end
   end

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                         input logic tsub, input int hold,
                         output logic [W-1:0] rs, output logic rc, output logic re);
      int guard;
      int lat;
      @(negedge clk);
      a = ta; b = tb; cIn = tcin; sub = tsub; inValid = 1'b1;
      guard = 0;
      while (!inReady && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!inReady) check("accept_timeout", 32'd0, 32'd1);
      model(ta, tb, tcin, tsub, exp_s, exp_c, exp_e);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      a = W'($urandom); b = W'($urandom); cIn = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!outValid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(DIGITS));
      rs = s; rc = cOut; re = err;
      for (int i = 0; i < hold; i++) begin
         inValid = 1'b1;
         @(posedge clk);
         #1;
         check("held_outValid", 32'(outValid), 32'd1);
         check("held_s", 32'(s), 32'(rs));
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      check("outValid_fall", 32'(outValid), 32'd0);
      check("inReady_back", 32'(inReady), 32'd1);
   endtask

   initial begin
      logic [W-1:0] rs;
      logic         rc, re;
      logic [W-1:0] ra, rb;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_inReady", 32'(inReady), 32'd1);
      check("rst_outValid", 32'(outValid), 32'd0);
      check("rst_s", 32'(s), 32'd0);
      check("rst_cOut", 32'(cOut), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      resetN = 1'b1;

      // 0012 + 0021 = 0110
      run_op(8'h06, 8'h09, 1'b0, 1'b0, 0, rs, rc, re);
      check("t1_s", 32'(rs), 32'h14);
      check("t1_cOut", 32'(rc), 32'd0);
      check("t1_err", 32'(re), 32'd0);

      // 2222 + 0001 = 1_0000 ; 0000 + 0000 + cIn = 0001
      run_op(8'hAA, 8'h01, 1'b0, 1'b0, 1, rs, rc, re);
      check("t2a_s", 32'(rs), 32'h00);
      check("t2a_cOut", 32'(rc), 32'd1);
      run_op(8'h00, 8'h00, 1'b1, 1'b0, 0, rs, rc, re);
      check("t2b_s", 32'(rs), 32'h01);
      check("t2b_cOut", 32'(rc), 32'd0);

      // Invalid digit 1 of a; err then clears on next valid accept
      run_op(8'h0C, 8'h01, 1'b0, 1'b0, 0, rs, rc, re);
      check("t3_s", 32'(rs), 32'h01);
      check("t3_err", 32'(re), 32'd1);
      check("t3_cOut", 32'(rc), 32'd0);
      run_op(8'h06, 8'h09, 1'b0, 1'b0, 0, rs, rc, re);
      check("t3_err_clear", 32'(re), 32'd0);

      // Hold DONE for 5 cycles with inValid asserted
      run_op(8'h25, 8'h16, 1'b1, 1'b0, 5, rs, rc, re);

      // Reset while digit 2 is being processed
      @(negedge clk);
      a = 8'h06; b = 8'h09; cIn = 1'b0; sub = 1'b0; inValid = 1'b1;
      @(posedge clk);
      #1 inValid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 resetN = 1'b0;
      #1;
      check("t5_s", 32'(s), 32'd0);
      check("t5_cOut", 32'(cOut), 32'd0);
      check("t5_err", 32'(err), 32'd0);
      check("t5_outValid", 32'(outValid), 32'd0);
      check("t5_inReady", 32'(inReady), 32'd1);
      @(negedge clk);
      resetN = 1'b1;
      run_op(8'h06, 8'h09, 1'b0, 1'b0, 0, rs, rc, re);
      check("t5_after_s", 32'(rs), 32'h14);

      // Subtract mode, or plain add when the feature is absent
`ifdef TERNARY_SUB_EN
      run_op(8'h14, 8'h09, 1'b0, 1'b1, 0, rs, rc, re);
      check("t6a_s", 32'(rs), 32'h06);
      check("t6a_cOut", 32'(rc), 32'd1);
      run_op(8'h00, 8'h01, 1'b1, 1'b1, 0, rs, rc, re);
      check("t6b_s", 32'(rs), 32'hAA);
      check("t6b_cOut", 32'(rc), 32'd0);
`else
      run_op(8'h14, 8'h09, 1'b0, 1'b1, 0, rs, rc, re);
      check("t6_s", 32'(rs), 32'h21);
      check("t6_cOut", 32'(rc), 32'd0);
`endif

      // Randomized operations against the model
      for (int n = 0; n < 60; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            ra = sanitize(ra);
            rb = sanitize(rb);
         end
         run_op(ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), rs, rc, re);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      check("global_timeout", 32'd0, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "time limit reached");
   end

endmodule
